// File: rtl/nios_mul_sequencer.sv
// Multi-pass controller for the shared 16x16 three-product multiply cell.
// It assembles MUL (low word) and MULXUU/MULXSU/MULXSS (signed-corrected high word) results.
module nios_mul_sequencer #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE1 = 3'd1;
  localparam logic [2:0] S_WAIT1  = 3'd2;
  localparam logic [2:0] S_CAP1   = 3'd3;
  localparam logic [2:0] S_ISSUE2 = 3'd4;
  localparam logic [2:0] S_WAIT2  = 3'd5;
  localparam logic [2:0] S_CAP2   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // Wait states cover the cell latency beyond the single issue cycle.
  localparam bit         HAS_WAIT  = (CELL_LATENCY > 1);
  localparam logic [1:0] WAIT_LAST = 2'((CELL_LATENCY > 1) ? CELL_LATENCY - 2 : 0);

  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [17:0] carry_q, carry_d;
  logic [31:0] result_q, result_d;

  logic [32:0] mid;
  logic [32:0] lo;
  logic [17:0] carry_next;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] hi;

  always_comb begin
    mid        = {1'b0, mul_p2} + {1'b0, mul_p3};
    lo         = {1'b0, mul_p1} + {1'b0, mid[15:0], 16'h0000};
    carry_next = {1'b0, mid[32:16]} + {17'd0, lo[32]};
    // op[1] marks src1 as signed (MULXSU and MULXSS).
    corr_a     = (a_q[31] && op_q[1]) ? b_q : 32'h0;
    corr_b     = (b_q[31] && (op_q == OP_MULXSS)) ? a_q : 32'h0;
    hi         = mul_p1 + {14'h0, carry_q} - corr_a - corr_b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_src1;
          b_d     = req_src2;
          state_d = S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        cnt_d   = 2'd0;
        state_d = HAS_WAIT ? S_WAIT1 : S_CAP1;
      end
      S_WAIT1: begin
        if (cnt_q == WAIT_LAST) state_d = S_CAP1;
        else                    cnt_d   = cnt_q + 2'd1;
      end
      S_CAP1: begin
        result_d = lo[31:0];
        carry_d  = carry_next;
        state_d  = (op_q == OP_MUL) ? S_DONE : S_ISSUE2;
      end
      S_ISSUE2: begin
        cnt_d   = 2'd0;
        state_d = HAS_WAIT ? S_WAIT2 : S_CAP2;
      end
      S_WAIT2: begin
        if (cnt_q == WAIT_LAST) state_d = S_CAP2;
        else                    cnt_d   = cnt_q + 2'd1;
      end
      S_CAP2: begin
        result_d = hi;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      op_q     <= 2'd0;
      a_q      <= 32'h0;
      b_q      <= 32'h0;
      carry_q  <= 18'h0;
      result_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_result = result_q;

  // Second pass reuses the lo*lo product lane to form hi*hi.
  always_comb begin
    mul_en   = 1'b0;
    mul_src1 = 32'h0;
    mul_src2 = 32'h0;
    case (state_q)
      S_ISSUE1, S_WAIT1: begin
        mul_en   = 1'b1;
        mul_src1 = a_q;
        mul_src2 = b_q;
      end
      S_ISSUE2, S_WAIT2: begin
        mul_en   = 1'b1;
        mul_src1 = {16'h0000, a_q[31:16]};
        mul_src2 = {16'h0000, b_q[31:16]};
      end
      default: begin
        mul_en   = 1'b0;
        mul_src1 = 32'h0;
        mul_src2 = 32'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_nios_mul_sequencer.sv
// Directed bench: one sequencer with CELL_LATENCY=1 and one with 3, each
// paired with a behavioural pipelined multiply cell.
module tb_nios_mul_sequencer;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_src1;
  logic [1:0][31:0] req_src2;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [1:0][31:0] resp_result;
  logic [1:0][31:0] mul_src1;
  logic [1:0][31:0] mul_src2;
  logic [1:0]       mul_en;
  logic [1:0][31:0] mul_p1;
  logic [1:0][31:0] mul_p2;
  logic [1:0][31:0] mul_p3;

  logic [1:0][3:0][31:0] pp1, pp2, pp3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  nios_mul_sequencer #(.CELL_LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_src1(req_src1[0]), .req_src2(req_src2[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_result(resp_result[0]),
    .mul_src1(mul_src1[0]), .mul_src2(mul_src2[0]), .mul_en(mul_en[0]),
    .mul_p1(mul_p1[0]), .mul_p2(mul_p2[0]), .mul_p3(mul_p3[0])
  );

  nios_mul_sequencer #(.CELL_LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_src1(req_src1[1]), .req_src2(req_src2[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_result(resp_result[1]),
    .mul_src1(mul_src1[1]), .mul_src2(mul_src2[1]), .mul_en(mul_en[1]),
    .mul_p1(mul_p1[1]), .mul_p2(mul_p2[1]), .mul_p3(mul_p3[1])
  );

  // Cell model: a pipeline that advances only on enabled edges and holds otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mul_en[d]) begin
        pp1[d][0] <= 32'(mul_src1[d][15:0])  * 32'(mul_src2[d][15:0]);
        pp2[d][0] <= 32'(mul_src1[d][15:0])  * 32'(mul_src2[d][31:16]);
        pp3[d][0] <= 32'(mul_src1[d][31:16]) * 32'(mul_src2[d][15:0]);
        for (int i = 1; i < 4; i++) begin
          pp1[d][i] <= pp1[d][i-1];
          pp2[d][i] <= pp2[d][i-1];
          pp3[d][i] <= pp3[d][i-1];
        end
      end
    end
  end

  assign mul_p1[0] = pp1[0][0];
  assign mul_p2[0] = pp2[0][0];
  assign mul_p3[0] = pp3[0][0];
  assign mul_p1[1] = pp1[1][2];
  assign mul_p2[1] = pp2[1][2];
  assign mul_p3[1] = pp3[1][2];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic run_txn(input int d, input int lat_l, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int k;
    int lat;
    int en_cnt;
    int exp_lat;
    int exp_en;
    logic [31:0] s1, s2, e1, e2;
    @(negedge clk);
    resp_ready[d] = 1'b1;
    req_op[d]     = op;
    req_src1[d]   = a;
    req_src2[d]   = b;
    req_valid[d]  = 1'b1;
    k = 0;
    while (!req_ready[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("dut%0d accept", d), 32'(req_ready[d]), 32'h1);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_op[d]    = ~op;
    req_src1[d]  = ~a;
    req_src2[d]  = ~b;
    lat    = 0;
    en_cnt = 0;
    s1     = 32'h0;
    s2     = 32'h0;
    @(negedge clk);
    while (!resp_valid[d] && lat < 40) begin
      if (mul_en[d]) begin
        en_cnt++;
        s1 = mul_src1[d];
        s2 = mul_src2[d];
      end
      @(negedge clk);
      lat++;
    end
    exp_lat = (op == OP_MUL) ? lat_l + 1 : 2 * lat_l + 2;
    exp_en  = (op == OP_MUL) ? lat_l : 2 * lat_l;
    e1      = (op == OP_MUL) ? a : {16'h0000, a[31:16]};
    e2      = (op == OP_MUL) ? b : {16'h0000, b[31:16]};
    check($sformatf("dut%0d op%0d result", d, op), resp_result[d], exp);
    check($sformatf("dut%0d op%0d latency", d, op), 32'(lat), 32'(exp_lat));
    check($sformatf("dut%0d op%0d mul_en cycles", d, op), 32'(en_cnt), 32'(exp_en));
    check($sformatf("dut%0d op%0d last pass src1", d, op), s1, e1);
    check($sformatf("dut%0d op%0d last pass src2", d, op), s2, e2);
    @(negedge clk);
    check($sformatf("dut%0d op%0d valid drops", d, op), 32'(resp_valid[d]), 32'h0);
    check($sformatf("dut%0d op%0d ready back", d, op), 32'(req_ready[d]), 32'h1);
    $display("txn dut%0d op=%0d a=%08h b=%08h result=%08h latency=%0d", d, op, a, b, resp_result[d], lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0]  = '{OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
    vecs[1]  = '{OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[5]  = '{OP_MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
    vecs[6]  = '{OP_MULXUU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
    vecs[7]  = '{OP_MULXSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[8]  = '{OP_MULXSS, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
    vecs[9]  = '{OP_MULXSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[10] = '{OP_MULXSS, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[11] = '{OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[12] = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[13] = '{OP_MULXUU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001};
    vecs[14] = '{OP_MULXSS, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};

    reset_n    = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    req_op     = '0;
    req_src1   = '0;
    req_src2   = '0;
    #2 reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("dut%0d reset req_ready", d), 32'(req_ready[d]), 32'h1);
      check($sformatf("dut%0d reset resp_valid", d), 32'(resp_valid[d]), 32'h0);
      check($sformatf("dut%0d reset resp_result", d), resp_result[d], 32'h0);
      check($sformatf("dut%0d reset mul_en", d), 32'(mul_en[d]), 32'h0);
      check($sformatf("dut%0d reset mul_src1", d), mul_src1[d], 32'h0);
      check($sformatf("dut%0d reset mul_src2", d), mul_src2[d], 32'h0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_txn(0, 1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    for (int i = 0; i < 15; i++) run_txn(1, 3, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Backpressure on the L=1 instance.
    @(negedge clk);
    resp_ready[0] = 1'b0;
    req_op[0]     = OP_MUL;
    req_src1[0]   = 32'h0001_0003;
    req_src2[0]   = 32'h0002_0005;
    req_valid[0]  = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!resp_valid[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp resp_valid rises", 32'(resp_valid[0]), 32'h1);
    req_valid[0] = 1'b1;
    req_op[0]    = OP_MULXUU;
    req_src1[0]  = 32'h0000_0003;
    req_src2[0]  = 32'h0000_0005;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold valid %0d", i), 32'(resp_valid[0]), 32'h1);
      check($sformatf("bp hold result %0d", i), resp_result[0], 32'h000B_000F);
      check($sformatf("bp req_ready low %0d", i), 32'(req_ready[0]), 32'h0);
      check($sformatf("bp no mul_en %0d", i), 32'(mul_en[0]), 32'h0);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp valid after handshake", 32'(resp_valid[0]), 32'h0);
    check("bp ready after handshake", 32'(req_ready[0]), 32'h1);
    $display("txn dut0 backpressure result=000b000f held 5 cycles");
    run_txn(0, 1, OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

    // Reset during WAIT2 on the L=3 instance.
    @(negedge clk);
    req_op[1]    = OP_MULXUU;
    req_src1[1]  = 32'hFFFF_FFFF;
    req_src2[1]  = 32'hFFFF_FFFF;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("abort in second pass mul_en", 32'(mul_en[1]), 32'h1);
    check("abort in second pass src1", mul_src1[1], 32'h0000_FFFF);
    reset_n = 1'b0;
    #1;
    check("abort async mul_en", 32'(mul_en[1]), 32'h0);
    check("abort async mul_src1", mul_src1[1], 32'h0);
    check("abort async mul_src2", mul_src2[1], 32'h0);
    check("abort async resp_valid", 32'(resp_valid[1]), 32'h0);
    check("abort async resp_result", resp_result[1], 32'h0);
    check("abort async req_ready", 32'(req_ready[1]), 32'h1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid[1]) k++;
    end
    check("abort no response", 32'(k), 32'h0);
    check("abort ready after release", 32'(req_ready[1]), 32'h1);
    $display("txn dut1 aborted MULXUU by reset");
    run_txn(1, 3, OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
